// File: rtl/sr_latch_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sr_latch_monitor                                             |
// | Description : Clocked observer for a cross-coupled NAND set/reset latch;  |
// |               tracks expected state, checks q/qbar, counts events and     |
// |               flags illegal drive and release races.                      |
// |               Optional macro SR_MON_GLITCH_FILTER_EN: a code must be seen |
// |               on two consecutive synced cycles before it is accepted.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sr_latch_monitor #(
  parameter int SETTLE_CYC = 3,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             preset_n,
  input  logic             clear_n,
  input  logic             q,
  input  logic             qbar,
  input  logic             err_clr,
  output logic             state_valid,
  output logic             latch_state,
  output logic             checking,
  output logic [CNT_W-1:0] set_cnt,
  output logic [CNT_W-1:0] clr_cnt,
  output logic             err_mismatch,
  output logic             err_illegal,
  output logic             err_race
);

  typedef enum logic [1:0] {
    ST_UNKNOWN = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_STABLE  = 2'd2,
    ST_FORCED  = 2'd3
  } state_t;

  localparam logic [3:0]       c_settle_init = 4'(SETTLE_CYC);
  localparam logic [3:0]       c_sync_rst    = 4'b1100;
  localparam logic [CNT_W-1:0] c_cnt_max     = '1;

  // Bit order in both sync stages: {preset_n, clear_n, q, qbar}
  logic [3:0]       meta_q, meta_d;
  logic [3:0]       sync_q, sync_d;
  logic [1:0]       code_prev_q, code_prev_d;
  state_t           state_q, state_d;
  logic [3:0]       settle_cnt_q, settle_cnt_d;
  logic [1:0]       exp_q, exp_d;
  logic             exp_known_q, exp_known_d;
  logic             state_valid_q, state_valid_d;
  logic             latch_state_q, latch_state_d;
  logic             checking_q, checking_d;
  logic [CNT_W-1:0] set_cnt_q, set_cnt_d;
  logic [CNT_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             err_mismatch_q, err_mismatch_d;
  logic             err_illegal_q, err_illegal_d;
  logic             err_race_q, err_race_d;

  logic [1:0] w_code;
  logic [1:0] w_qs;
  logic       w_pending;
  logic       w_accept;
  logic       w_cmp_en;
  logic       w_illegal_set;
  logic       w_race_set;

  assign w_code    = sync_q[3:2];
  assign w_qs      = sync_q[1:0];
  assign w_pending = (w_code != code_prev_q);

`ifdef SR_MON_GLITCH_FILTER_EN
  logic [1:0] code_hold_q, code_hold_d;
  assign code_hold_d = w_code;
  assign w_accept    = w_pending && (w_code == code_hold_q);
  always_ff @(posedge clk) begin
    if (rst) code_hold_q <= 2'b11;
    else     code_hold_q <= code_hold_d;
  end
`else
  assign w_accept = w_pending;
`endif

  // Comparison is held off while a drive change is in flight, so q/qbar
  // moving alongside the drive never looks like a mismatch.
  assign w_cmp_en = !w_pending &&
                    ((state_q == ST_STABLE) || (state_q == ST_FORCED) ||
                     ((state_q == ST_SETTLE) && (settle_cnt_q == 4'd1) && exp_known_q));

  always_comb begin
    meta_d        = {preset_n, clear_n, q, qbar};
    sync_d        = meta_q;
    code_prev_d   = code_prev_q;
    state_d       = state_q;
    settle_cnt_d  = settle_cnt_q;
    exp_d         = exp_q;
    exp_known_d   = exp_known_q;
    state_valid_d = state_valid_q;
    latch_state_d = latch_state_q;
    checking_d    = checking_q;
    set_cnt_d     = set_cnt_q;
    clr_cnt_d     = clr_cnt_q;
    w_illegal_set = 1'b0;
    w_race_set    = 1'b0;

    if (w_accept) begin
      code_prev_d  = w_code;
      state_d      = ST_SETTLE;
      settle_cnt_d = c_settle_init;
      checking_d   = 1'b0;
      case (w_code)
        2'b01: begin
          exp_d         = 2'b10;
          exp_known_d   = 1'b1;
          latch_state_d = 1'b1;
          state_valid_d = 1'b1;
          if (set_cnt_q != c_cnt_max) set_cnt_d = set_cnt_q + CNT_W'(1);
        end
        2'b10: begin
          exp_d         = 2'b01;
          exp_known_d   = 1'b1;
          latch_state_d = 1'b0;
          state_valid_d = 1'b1;
          if (clr_cnt_q != c_cnt_max) clr_cnt_d = clr_cnt_q + CNT_W'(1);
        end
        2'b00: begin
          exp_d         = 2'b11;
          exp_known_d   = 1'b1;
          state_valid_d = 1'b0;
          w_illegal_set = 1'b1;
        end
        default: begin
          if (code_prev_q == 2'b00) begin
            exp_known_d   = 1'b0;
            state_valid_d = 1'b0;
            w_race_set    = 1'b1;
          end else begin
            exp_d         = {latch_state_q, ~latch_state_q};
            exp_known_d   = 1'b1;
            state_valid_d = 1'b1;
          end
        end
      endcase
    end else begin
      case (state_q)
        ST_SETTLE: begin
          if (settle_cnt_q == 4'd1) begin
            if (!exp_known_q) begin
              state_d       = ST_UNKNOWN;
              state_valid_d = 1'b0;
              checking_d    = 1'b0;
            end else if (code_prev_q == 2'b00) begin
              state_d       = ST_FORCED;
              state_valid_d = 1'b0;
              checking_d    = 1'b1;
            end else begin
              state_d       = ST_STABLE;
              state_valid_d = 1'b1;
              checking_d    = 1'b1;
            end
          end else begin
            settle_cnt_d = settle_cnt_q - 4'd1;
          end
        end
        ST_UNKNOWN: begin
          if ((w_qs[1] != w_qs[0]) && (w_code == 2'b11)) begin
            latch_state_d = w_qs[1];
            exp_d         = w_qs;
            exp_known_d   = 1'b1;
            state_d       = ST_STABLE;
            state_valid_d = 1'b1;
            checking_d    = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end

    // Sticky flags: a new error in the same cycle as err_clr wins
    err_mismatch_d = (w_cmp_en && (w_qs != exp_q)) || (err_mismatch_q && !err_clr);
    err_illegal_d  = w_illegal_set || (err_illegal_q && !err_clr);
    err_race_d     = w_race_set || (err_race_q && !err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q         <= c_sync_rst;
      sync_q         <= c_sync_rst;
      code_prev_q    <= 2'b11;
      state_q        <= ST_UNKNOWN;
      settle_cnt_q   <= 4'd0;
      exp_q          <= 2'b00;
      exp_known_q    <= 1'b0;
      state_valid_q  <= 1'b0;
      latch_state_q  <= 1'b0;
      checking_q     <= 1'b0;
      set_cnt_q      <= '0;
      clr_cnt_q      <= '0;
      err_mismatch_q <= 1'b0;
      err_illegal_q  <= 1'b0;
      err_race_q     <= 1'b0;
    end else begin
      meta_q         <= meta_d;
      sync_q         <= sync_d;
      code_prev_q    <= code_prev_d;
      state_q        <= state_d;
      settle_cnt_q   <= settle_cnt_d;
      exp_q          <= exp_d;
      exp_known_q    <= exp_known_d;
      state_valid_q  <= state_valid_d;
      latch_state_q  <= latch_state_d;
      checking_q     <= checking_d;
      set_cnt_q      <= set_cnt_d;
      clr_cnt_q      <= clr_cnt_d;
      err_mismatch_q <= err_mismatch_d;
      err_illegal_q  <= err_illegal_d;
      err_race_q     <= err_race_d;
    end
  end

  assign state_valid  = state_valid_q;
  assign latch_state  = latch_state_q;
  assign checking     = checking_q;
  assign set_cnt      = set_cnt_q;
  assign clr_cnt      = clr_cnt_q;
  assign err_mismatch = err_mismatch_q;
  assign err_illegal  = err_illegal_q;
  assign err_race     = err_race_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_latch_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sr_latch_monitor                                          |
// | Description : Directed vector bench for sr_latch_monitor.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sr_latch_monitor;

`ifdef SR_MON_GLITCH_FILTER_EN
  localparam int ACC = 4;
`else
  localparam int ACC = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       preset_n = 1'b1;
  logic       clear_n = 1'b1;
  logic       q = 1'b0;
  logic       qbar = 1'b1;
  logic       err_clr = 1'b0;
  logic       state_valid, latch_state, checking;
  logic [7:0] set_cnt, clr_cnt;
  logic       err_mismatch, err_illegal, err_race;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sr_latch_monitor #(.SETTLE_CYC(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .preset_n(preset_n), .clear_n(clear_n),
    .q(q), .qbar(qbar), .err_clr(err_clr),
    .state_valid(state_valid), .latch_state(latch_state), .checking(checking),
    .set_cnt(set_cnt), .clr_cnt(clr_cnt), .err_mismatch(err_mismatch),
    .err_illegal(err_illegal), .err_race(err_race)
  );

  typedef struct {
    logic rst, pn, cn, q, qb;
    int   ncyc;
    logic sv, ls, chk;
    int   setc, clrc;
    logic em, ei, er;
  } vec_t;

  vec_t tbl[8];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int hits;
    int edge_no;
    //          rst pn cn q qb ncyc  sv ls chk set clr em ei er
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1,  2, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1,  5, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10, 1'b1, 1'b1, 1'b1, 1, 0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10, 1'b1, 1'b1, 1'b1, 1, 0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10, 1'b1, 1'b0, 1'b1, 1, 1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10, 1'b1, 1'b0, 1'b1, 1, 1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10, 1'b1, 1'b1, 1'b1, 2, 1, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10, 1'b1, 1'b1, 1'b1, 2, 1, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 8; i++) begin
      rst = tbl[i].rst; preset_n = tbl[i].pn; clear_n = tbl[i].cn;
      q = tbl[i].q; qbar = tbl[i].qb;
      step(tbl[i].ncyc);
      cmp($sformatf("v%0d.state_valid", i), 32'(state_valid), 32'(tbl[i].sv));
      cmp($sformatf("v%0d.latch_state", i), 32'(latch_state), 32'(tbl[i].ls));
      cmp($sformatf("v%0d.checking", i), 32'(checking), 32'(tbl[i].chk));
      cmp($sformatf("v%0d.set_cnt", i), 32'(set_cnt), 32'(tbl[i].setc));
      cmp($sformatf("v%0d.clr_cnt", i), 32'(clr_cnt), 32'(tbl[i].clrc));
      cmp($sformatf("v%0d.err_mismatch", i), 32'(err_mismatch), 32'(tbl[i].em));
      cmp($sformatf("v%0d.err_illegal", i), 32'(err_illegal), 32'(tbl[i].ei));
      cmp($sformatf("v%0d.err_race", i), 32'(err_race), 32'(tbl[i].er));
    end

    // Clear with a well-behaved latch: exact settle timing
    clear_n = 1'b0; q = 1'b0; qbar = 1'b1;
    step(ACC - 1);
    cmp("clrA.checking_pre", 32'(checking), 32'd1);
    cmp("clrA.clr_cnt_pre", 32'(clr_cnt), 32'd1);
    step(1);
    cmp("clrA.checking_acc", 32'(checking), 32'd0);
    cmp("clrA.clr_cnt_acc", 32'(clr_cnt), 32'd2);
    cmp("clrA.latch_state_acc", 32'(latch_state), 32'd0);
    cmp("clrA.state_valid_acc", 32'(state_valid), 32'd1);
    step(2);
    cmp("clrA.checking_settle", 32'(checking), 32'd0);
    step(1);
    cmp("clrA.checking_on", 32'(checking), 32'd1);
    cmp("clrA.err_mismatch", 32'(err_mismatch), 32'd0);
    clear_n = 1'b1;
    step(10);

    // Clear while q stays high: mismatch on the settle-expiry edge
    preset_n = 1'b0; q = 1'b1; qbar = 1'b0;
    step(10);
    preset_n = 1'b1;
    step(10);
    cmp("clrB.set_cnt", 32'(set_cnt), 32'd3);
    clear_n = 1'b0;
    step(ACC + 2);
    cmp("clrB.err_mismatch_early", 32'(err_mismatch), 32'd0);
    cmp("clrB.clr_cnt", 32'(clr_cnt), 32'd3);
    step(1);
    cmp("clrB.err_mismatch_set", 32'(err_mismatch), 32'd1);
    q = 1'b0; qbar = 1'b1;
    step(4);
    cmp("clrB.err_mismatch_sticky", 32'(err_mismatch), 32'd1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    cmp("clrB.err_mismatch_cleared", 32'(err_mismatch), 32'd0);
    clear_n = 1'b1;
    step(10);
    cmp("clrB.err_mismatch_after", 32'(err_mismatch), 32'd0);

    // Illegal both-low drive, forced check, then racing release
    preset_n = 1'b0; clear_n = 1'b0; q = 1'b1; qbar = 1'b1;
    step(ACC);
    cmp("ill.err_illegal", 32'(err_illegal), 32'd1);
    cmp("ill.state_valid_settle", 32'(state_valid), 32'd0);
    cmp("ill.checking_settle", 32'(checking), 32'd0);
    step(3);
    cmp("ill.checking_forced", 32'(checking), 32'd1);
    cmp("ill.state_valid_forced", 32'(state_valid), 32'd0);
    cmp("ill.err_mismatch", 32'(err_mismatch), 32'd0);
    step(8 - (ACC + 3));
    preset_n = 1'b1; clear_n = 1'b1;
    step(ACC);
    cmp("race.err_race", 32'(err_race), 32'd1);
    cmp("race.state_valid", 32'(state_valid), 32'd0);
    step(10);
    cmp("race.state_valid_unknown", 32'(state_valid), 32'd0);
    cmp("race.checking_unknown", 32'(checking), 32'd0);
    cmp("race.err_mismatch", 32'(err_mismatch), 32'd0);
    q = 1'b0; qbar = 1'b1;
    step(2);
    cmp("race.state_valid_wait", 32'(state_valid), 32'd0);
    step(1);
    cmp("race.state_valid_adopt", 32'(state_valid), 32'd1);
    cmp("race.latch_state_adopt", 32'(latch_state), 32'd0);
    cmp("race.err_illegal_sticky", 32'(err_illegal), 32'd1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    cmp("race.err_illegal_cleared", 32'(err_illegal), 32'd0);
    cmp("race.err_race_cleared", 32'(err_race), 32'd0);

    // Rapid clear toggling: counter saturates, settle never expires
    hits = 0;
    edge_no = 0;
    q = 1'b0; qbar = 1'b0;
    for (int k = 0; k < 300; k++) begin
      clear_n = 1'b0;
      for (int j = 0; j < 4; j++) begin
        if (j == 2) begin
          clear_n = 1'b1;
          if (k == 299) begin
            q = 1'b0; qbar = 1'b1;
          end
        end
        step(1);
        edge_no++;
        if (edge_no >= ACC && checking) hits++;
      end
    end
    cmp("tog.checking_hits", 32'(hits), 32'd0);
    step(10);
    cmp("tog.clr_cnt_sat", 32'(clr_cnt), 32'd255);
    cmp("tog.err_mismatch", 32'(err_mismatch), 32'd0);
    cmp("tog.checking_end", 32'(checking), 32'd1);
    cmp("tog.latch_state", 32'(latch_state), 32'd0);

    // Single-cycle preset glitch
    preset_n = 1'b0;
    step(1);
    preset_n = 1'b1;
    step(10);
`ifdef SR_MON_GLITCH_FILTER_EN
    cmp("glitch.set_cnt", 32'(set_cnt), 32'd3);
    cmp("glitch.latch_state", 32'(latch_state), 32'd0);
    cmp("glitch.err_mismatch", 32'(err_mismatch), 32'd0);
`else
    cmp("glitch.set_cnt", 32'(set_cnt), 32'd4);
    cmp("glitch.latch_state", 32'(latch_state), 32'd1);
    cmp("glitch.err_mismatch", 32'(err_mismatch), 32'd1);
`endif
    cmp("glitch.err_illegal", 32'(err_illegal), 32'd0);
    cmp("glitch.err_race", 32'(err_race), 32'd0);

    // Mid-operation reset
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    cmp("rst.state_valid", 32'(state_valid), 32'd0);
    cmp("rst.latch_state", 32'(latch_state), 32'd0);
    cmp("rst.checking", 32'(checking), 32'd0);
    cmp("rst.set_cnt", 32'(set_cnt), 32'd0);
    cmp("rst.clr_cnt", 32'(clr_cnt), 32'd0);
    cmp("rst.err_mismatch", 32'(err_mismatch), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sr_latch_monitor.md
Name: sr_latch_monitor

Overview:
- Clocked, synthesizable observer for the far side of a cross-coupled NAND set/reset latch.
- Watches the latch's active-low preset_n/clear_n drive and its q/qbar response.
- Tracks the expected latch state, checks q/qbar against it after a settle window, counts set/clear events, and flags illegal drive and release races.
- Sits beside any NAND flip-flop instance as a synthesizable checker, replacing hand-inspected stimulus waveforms.

Parameters:
- SETTLE_CYC, 3, clock cycles after an accepted input change before q/qbar are checked (legal range 1..15).
- CNT_W, 8, width of the saturating event counters.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- preset_n  input  1  latch preset drive, active low, asynchronous to clk
- clear_n  input  1  latch clear drive, active low, asynchronous to clk
- q  input  1  latch q output, asynchronous
- qbar  input  1  latch qbar output, asynchronous
- err_clr  input  1  one-cycle pulse; clears all sticky error flags
- state_valid  output  1  expected state is known
- latch_state  output  1  expected q value
- checking  output  1  FSM is in STABLE or FORCED and comparing this cycle
- set_cnt  output  CNT_W  number of accepted preset assertions (saturating)
- clr_cnt  output  CNT_W  number of accepted clear assertions (saturating)
- err_mismatch  output  1  sticky: q/qbar differed from expected while checking
- err_illegal  output  1  sticky: preset_n and clear_n both low
- err_race  output  1  sticky: both inputs released together from both-low

Behaviour:
- Sync and decode
  - preset_n, clear_n, q and qbar each pass through a 2-flop synchronizer. Identical depth keeps inputs and outputs aligned.
  - code = {preset_n_s, clear_n_s}. code_prev is registered.
  - A change is accepted in the cycle where code != code_prev.
  - FSM and outputs react on the edge after acceptance, i.e. 3 clk edges after a pin change.
- Expected values on an accepted change
  - 01 (preset): exp = {q=1, qbar=0}; set_cnt+1.
  - 10 (clear): exp = {0,1}; clr_cnt+1.
  - 00 (illegal): exp = {1,1}; err_illegal set.
  - 11 reached from 01 or 10: exp holds {latch_state, ~latch_state}.
  - 11 reached from 00: err_race set; exp becomes unknown.
- States: UNKNOWN, SETTLE, STABLE, FORCED.
- Reset state: UNKNOWN, state_valid=0, latch_state=0, checking=0, counters=0, all error flags=0, code_prev=11.
- Transitions
  - Any accepted change, from any state: go to SETTLE and load settle_cnt=SETTLE_CYC.
  - A change during SETTLE restarts the window with the new expectation.
  - SETTLE: decrement settle_cnt; at 1, go to:
    - STABLE for code 01/10/11 with known exp,
    - FORCED for code 00,
    - UNKNOWN after a race.
  - STABLE: compare {q_s, qbar_s} to exp every cycle; a difference sets err_mismatch. state_valid=1.
  - FORCED: compare against {1,1}. state_valid=0.
  - UNKNOWN (reset or race): no compare. When q_s != qbar_s and code==11, adopt latch_state=q_s and go to STABLE; state_valid rises the same edge.
- During SETTLE
  - checking=0.
  - state_valid=1 only if exp is known and complementary.
  - latch_state updates on entry to SETTLE for 01/10.
- Counters: saturate at 2^CNT_W-1; they count events only, not cycles.
- Errors: sticky until err_clr. If err_clr and a new error occur in the same cycle, the set wins.
- rst mid-operation: returns to the reset state on the next edge; synchronizer flops also clear (to 1 for preset_n/clear_n, 0 for q/qbar).

Optional Feature:
- Macro: SR_MON_GLITCH_FILTER_EN.
- Defined: a new code must be seen identical on 2 consecutive synced cycles before acceptance. A single-cycle pulse on preset_n or clear_n is ignored: no count, no error. Acceptance latency becomes 4 edges after a pin change.
- Undefined: every synced code change is accepted immediately (3-edge latency).

Test Plan:
- Reset, then preset_n=1, clear_n=1, q=0, qbar=1 held 5 cycles -> UNKNOWN resolves: state_valid=1, latch_state=0, all errors 0.
- Pulse preset_n low 6 cycles with q=1, qbar=0 (SETTLE_CYC=3), then release -> set_cnt=1, latch_state=1, checking=1 from 6 edges after the pin change, err_mismatch=0.
- Clear pulse, but q stays 1 after settle -> clr_cnt=1, err_mismatch=1 exactly 6 edges after the clear_n fall; pulse err_clr -> 0 next edge.
- preset_n=clear_n=0 for 5 cycles with q=qbar=1, then both released together -> err_illegal=1, FORCED with no mismatch, then err_race=1 and state_valid=0 until q/qbar are complementary.
- Toggle clear_n every 2 cycles for 300 events (CNT_W=8) -> clr_cnt saturates at 255; no check fires during repeated SETTLE restarts.
- With SR_MON_GLITCH_FILTER_EN, 1-cycle preset_n low pulse -> set_cnt unchanged, no error. Without the macro -> set_cnt=1.
